// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the memory-stage access unit:
//               opcode encodings, common constants, the FSM state encoding,
//               load-type encoding and the opcode/byte-lane helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam int c_opcode_width = 6;
    localparam logic [31:0] c_zero_word = 32'h0000_0000;

    // MIPS-I primary opcodes of the memory instructions
    localparam logic [c_opcode_width-1:0] c_op_nop = 6'h00;
    localparam logic [c_opcode_width-1:0] c_op_lb  = 6'h20;
    localparam logic [c_opcode_width-1:0] c_op_lh  = 6'h21;
    localparam logic [c_opcode_width-1:0] c_op_lw  = 6'h23;
    localparam logic [c_opcode_width-1:0] c_op_lbu = 6'h24;
    localparam logic [c_opcode_width-1:0] c_op_lhu = 6'h25;
    localparam logic [c_opcode_width-1:0] c_op_sb  = 6'h28;
    localparam logic [c_opcode_width-1:0] c_op_sh  = 6'h29;
    localparam logic [c_opcode_width-1:0] c_op_sw  = 6'h2b;

    // Access FSM state encoding
    localparam int          c_state_width = 2;
    localparam logic [1:0]  c_st_idle     = 2'd0;
    localparam logic [1:0]  c_st_req      = 2'd1;
    localparam logic [1:0]  c_st_resp     = 2'd2;

    // Access size and load type
    typedef enum logic [1:0] {
        c_size_byte = 2'd0,
        c_size_half = 2'd1,
        c_size_word = 2'd2
    } mem_size_t;

    typedef struct packed {
        mem_size_t size;
        logic      is_signed;
    } load_type_t;

    typedef struct packed {
        logic       is_mem;
        logic       we;
        load_type_t ltype;
    } mem_op_t;

    // Classify an opcode; stores reuse ltype.size for their width.
    function automatic mem_op_t decode_op(input logic [c_opcode_width-1:0] op);
        mem_op_t d;
        d.is_mem          = 1'b1;
        d.we              = 1'b0;
        d.ltype.size      = c_size_word;
        d.ltype.is_signed = 1'b0;
        case (op)
            c_op_lb:  begin d.ltype.size = c_size_byte; d.ltype.is_signed = 1'b1; end
            c_op_lbu: d.ltype.size = c_size_byte;
            c_op_lh:  begin d.ltype.size = c_size_half; d.ltype.is_signed = 1'b1; end
            c_op_lhu: d.ltype.size = c_size_half;
            c_op_lw:  d.ltype.size = c_size_word;
            c_op_sb:  begin d.ltype.size = c_size_byte; d.we = 1'b1; end
            c_op_sh:  begin d.ltype.size = c_size_half; d.we = 1'b1; end
            c_op_sw:  begin d.ltype.size = c_size_word; d.we = 1'b1; end
            default:  d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

    // Big-endian lanes: offset 0 is bit 3 of the enable (bits 31:24).
    function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            c_size_byte: be = 4'b1000 >> off;
            c_size_half: be = off[1] ? 4'b0011 : 4'b1100;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        logic mis;
        case (size)
            c_size_byte: mis = 1'b0;
            c_size_half: mis = off[0];
            default:     mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory bus between the access unit (master) and the
//               memory (slave).
//   bus_req   master->slave  request strobe
//   bus_we    master->slave  1 = write
//   bus_addr  master->slave  word-aligned address
//   bus_be    master->slave  byte enables, bit 3 = bits 31:24
//   bus_wdata master->slave  store data
//   bus_rdata slave->master  read data, valid with bus_ack
//   bus_ack   slave->master  transfer complete
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_load_formatter
// Description : Combinational load-data formatter. Selects the addressed
//               byte or halfword (big-endian lanes) and sign/zero extends.
//   i_rdata    raw bus read word
//   i_byte_off address bits [1:0] of the access
//   i_ltype    access size and signed flag
//   o_data     formatted 32-bit load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit_load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_byte_off,
    input  load_type_t  i_ltype,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_byte_off[1] ? i_rdata[15:0] : i_rdata[31:16];

        case (i_ltype.size)
            c_size_byte: o_data = {{24{i_ltype.is_signed & w_byte[7]}}, w_byte};
            c_size_half: o_data = {{16{i_ltype.is_signed & w_half[15]}}, w_half};
            default:     o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage bus controller. Takes one load/store from the
//               MEM stage, computes byte enables, runs a req/ack handshake
//               with data memory (aborting after TIMEOUT request cycles),
//               stalls the pipeline until the access resolves and returns
//               sign/zero-extended load data.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   mem_valid  MEM stage holds a valid instruction
//   opcode     instruction opcode
//   addr       effective byte address
//   wdata      lane-replicated store data
//   stall_req  hold the pipeline
//   done       one-cycle pulse, access resolved
//   load_data  formatted load result (valid with done)
//   addr_err   with done: misaligned, no bus cycle issued
//   bus_err    with done: timeout abort
//   bus        data-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 15   // must be >= 2
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    input  logic [c_opcode_width-1:0] opcode,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall_req,
    output logic                      done,
    output logic [31:0]               load_data,
    output logic                      addr_err,
    output logic                      bus_err,
    mem_access_unit_if.master         bus
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT - 1);

    logic [c_state_width-1:0] r_state;
    logic [c_state_width-1:0] w_state_nxt;

    // Latched access attributes, held stable for the whole REQ phase
    logic               r_we;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    load_type_t         r_ltype;
    logic [1:0]         r_off;
    logic [c_cnt_w-1:0] r_cnt;

    logic [31:0]        r_load_data;
    logic               r_addr_err;
    logic               r_bus_err;

    mem_op_t            w_dec;
    logic               w_mem_op;
    logic               w_misaligned;
    logic               w_cnt_last;
    logic [31:0]        w_fmt_data;
    logic               w_stall;
    logic               w_done;
    logic               w_bus_req;

    assign w_dec        = decode_op(opcode);
    assign w_mem_op     = mem_valid & w_dec.is_mem;
    assign w_misaligned = is_misaligned(w_dec.ltype.size, addr[1:0]);
    assign w_cnt_last   = (r_cnt == c_cnt_max);

    mem_access_unit_load_formatter u_load_formatter (
        .i_rdata    (bus.bus_rdata),
        .i_byte_off (r_off),
        .i_ltype    (r_ltype),
        .o_data     (w_fmt_data)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_mem_op) begin
                    w_state_nxt = w_misaligned ? c_st_resp : c_st_req;
                end
            end
            c_st_req: begin
                // An ack on the final allowed cycle still completes normally
                if (bus.bus_ack || w_cnt_last) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_stall   = 1'b0;
        w_done    = 1'b0;
        w_bus_req = 1'b0;
        case (r_state)
            c_st_idle: w_stall = w_mem_op;
            c_st_req: begin
                w_stall   = 1'b1;
                w_bus_req = 1'b1;
            end
            c_st_resp: w_done = 1'b1;
            default: ;
        endcase
    end

    // The idle stall is combinational from the inputs, so it is masked by
    // reset to keep every output low while rst is asserted.
    assign stall_req = w_stall & rst;
    assign done      = w_done;
    assign load_data = r_load_data;
    assign addr_err  = r_addr_err;
    assign bus_err   = r_bus_err;

    assign bus.bus_req   = w_bus_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_be    = w_bus_req ? r_be : 4'b0000;
    assign bus.bus_wdata = r_wdata;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we        <= 1'b0;
            r_addr      <= c_zero_word;
            r_be        <= 4'b0000;
            r_wdata     <= c_zero_word;
            r_ltype     <= '0;
            r_off       <= 2'b00;
            r_cnt       <= '0;
            r_load_data <= c_zero_word;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_mem_op) begin
                        if (w_misaligned) begin
                            r_addr_err  <= 1'b1;
                            r_load_data <= c_zero_word;
                        end else begin
                            r_we    <= w_dec.we;
                            r_addr  <= {addr[31:2], 2'b00};
                            r_be    <= byte_enable(w_dec.ltype.size, addr[1:0]);
                            r_wdata <= wdata;
                            r_ltype <= w_dec.ltype;
                            r_off   <= addr[1:0];
                            r_cnt   <= '0;
                        end
                    end
                end
                c_st_req: begin
                    if (bus.bus_ack) begin
                        r_load_data <= r_we ? c_zero_word : w_fmt_data;
                    end else if (w_cnt_last) begin
                        r_bus_err   <= 1'b1;
                        r_load_data <= c_zero_word;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_resp: begin
                    // Results are only meaningful alongside done
                    r_load_data <= c_zero_word;
                    r_addr_err  <= 1'b0;
                    r_bus_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Directed scenarios
//               plus randomized accesses checked against a byte-arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int c_timeout = 15;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_req;
    logic        done;
    logic [31:0] load_data;
    logic        addr_err;
    logic        bus_err;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(c_timeout)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .opcode    (opcode),
        .addr      (addr),
        .wdata     (wdata),
        .stall_req (stall_req),
        .done      (done),
        .load_data (load_data),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .bus       (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Measurements of the last access
    int          m_done_cyc;
    int          m_stalls;
    int          m_reqs;
    bit          m_got_done;
    bit          m_stable;
    bit          m_leak;
    logic [31:0] m_ld;
    logic        m_aerr;
    logic        m_berr;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wd;

    // ---------------------------------------------------- reference model
    function automatic int nbytes(input logic [5:0] op);
        if (op == c_op_lb || op == c_op_lbu || op == c_op_sb) return 1;
        if (op == c_op_lh || op == c_op_lhu || op == c_op_sh) return 2;
        return 4;
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == c_op_sb || op == c_op_sh || op == c_op_sw);
    endfunction

    function automatic bit op_signed(input logic [5:0] op);
        return (op == c_op_lb || op == c_op_lh);
    endfunction

    function automatic logic [3:0] model_be(input int n, input int off);
        int v;
        v = ((1 << n) - 1) << (4 - n - off);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          n;
        int          shift;
        logic [63:0] mask;
        logic [63:0] v;
        n     = nbytes(op);
        shift = 8 * (4 - n - int'(a % 4));
        mask  = (64'h1 << (8 * n)) - 64'h1;
        v     = ({32'h0, rd} >> shift) & mask;
        if (op_signed(op) && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ------------------------------------------------------------- driver
    // Entered just after a rising edge. Presents one instruction, plays the
    // memory (ack after ack_wait REQ cycles, never if negative) and records
    // what the unit did until done.
    task automatic run_access(input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_wait);
        int cyc;
        opcode = op; addr = a; wdata = wd; mem_valid = 1'b1;
        bus_if.bus_rdata = rd;
        bus_if.bus_ack   = 1'b0;
        cyc = 0; m_stalls = 0; m_reqs = 0; m_got_done = 0;
        m_stable = 1; m_leak = 0; m_done_cyc = -1;
        m_ld = '0; m_aerr = 0; m_berr = 0;
        m_we = 0; m_addr = '0; m_be = '0; m_wd = '0;
        while (!m_got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (stall_req) m_stalls++;
            if (bus_if.bus_req) begin
                if (m_reqs == 0) begin
                    m_we = bus_if.bus_we; m_addr = bus_if.bus_addr;
                    m_be = bus_if.bus_be; m_wd = bus_if.bus_wdata;
                end else if (m_we !== bus_if.bus_we || m_addr !== bus_if.bus_addr ||
                             m_be !== bus_if.bus_be || m_wd !== bus_if.bus_wdata) begin
                    m_stable = 0;
                end
                bus_if.bus_ack = (m_reqs == ack_wait);
                m_reqs++;
            end else begin
                if (bus_if.bus_be !== 4'b0000) m_leak = 1;
            end
            if (done) begin
                m_got_done = 1; m_done_cyc = cyc;
                m_ld = load_data; m_aerr = addr_err; m_berr = bus_err;
            end else if (load_data !== 32'h0 || addr_err !== 1'b0 || bus_err !== 1'b0) begin
                m_leak = 1;
            end
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
        end
        mem_valid = 1'b0; opcode = c_op_nop;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b0; mem_valid = 1'b1; opcode = c_op_lw; addr = 32'h100; wdata = 32'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({stall_req, done, load_data, addr_err, bus_err, bus_if.bus_req, bus_if.bus_we,
             bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata} !== '0) begin
            bad++; $display("FAIL reset_outputs: got stall=%b done=%b req=%b be=%h, all want 0",
                            stall_req, done, bus_if.bus_req, bus_if.bus_be);
        end
        mem_valid = 1'b0; opcode = c_op_nop; rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_access(c_op_lw, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        total++; if (m_be !== 4'b1111 || m_addr !== 32'h100) begin
            bad++; $display("FAIL lw_bus: got be=%b addr=%h want be=1111 addr=00000100", m_be, m_addr); end
        total++; if (m_done_cyc != 3) begin
            bad++; $display("FAIL lw_done_cycle: got %0d want 3", m_done_cyc); end
        total++; if (m_ld !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_data: got %h want deadbeef", m_ld); end
        total++; if (m_stalls != 2 || m_leak) begin
            bad++; $display("FAIL lw_stalls: got %0d leak=%0d want 2 leak=0", m_stalls, m_leak); end
    endtask

    task automatic test_lb();
        run_access(c_op_lb, 32'h103, 32'h0, 32'h123456F0, 0);
        total++; if (m_be !== 4'b0001) begin
            bad++; $display("FAIL lb_be: got %b want 0001", m_be); end
        total++; if (m_ld !== 32'hFFFFFFF0) begin
            bad++; $display("FAIL lb_data: got %h want fffffff0", m_ld); end
        run_access(c_op_lbu, 32'h103, 32'h0, 32'h123456F0, 0);
        total++; if (m_ld !== 32'h000000F0) begin
            bad++; $display("FAIL lbu_data: got %h want 000000f0", m_ld); end
    endtask

    task automatic test_sh_wait();
        run_access(c_op_sh, 32'h202, 32'hABCDABCD, 32'h11111111, 3);
        total++; if (m_we !== 1'b1 || m_be !== 4'b0011 || m_wd !== 32'hABCDABCD || m_addr !== 32'h200) begin
            bad++; $display("FAIL sh_bus: got we=%b be=%b wd=%h addr=%h want 1 0011 abcdabcd 00000200",
                            m_we, m_be, m_wd, m_addr); end
        total++; if (m_reqs != 4 || !m_stable) begin
            bad++; $display("FAIL sh_req_len: got reqs=%0d stable=%0d want 4 1", m_reqs, m_stable); end
        total++; if (m_ld !== 32'h0 || m_done_cyc != 6) begin
            bad++; $display("FAIL sh_result: got ld=%h cyc=%0d want 0 6", m_ld, m_done_cyc); end
    endtask

    task automatic test_misaligned();
        run_access(c_op_lw, 32'h101, 32'h0, 32'hCAFEF00D, 0);
        total++; if (m_aerr !== 1'b1 || m_berr !== 1'b0 || m_done_cyc != 2) begin
            bad++; $display("FAIL mis_err: got aerr=%b berr=%b cyc=%0d want 1 0 2", m_aerr, m_berr, m_done_cyc); end
        total++; if (m_reqs != 0 || m_stalls != 1 || m_ld !== 32'h0) begin
            bad++; $display("FAIL mis_bus: got reqs=%0d stalls=%0d ld=%h want 0 1 0", m_reqs, m_stalls, m_ld); end
    endtask

    task automatic test_timeout();
        run_access(c_op_sw, 32'h300, 32'h87654321, 32'h0, -1);
        total++; if (m_reqs != c_timeout || m_berr !== 1'b1 || m_done_cyc != c_timeout + 2) begin
            bad++; $display("FAIL timeout: got reqs=%0d berr=%b cyc=%0d want %0d 1 %0d",
                            m_reqs, m_berr, m_done_cyc, c_timeout, c_timeout + 2); end
        run_access(c_op_lw, 32'h304, 32'h0, 32'h0BADCAFE, c_timeout - 1);
        total++; if (m_reqs != c_timeout || m_berr !== 1'b0 || m_ld !== 32'h0BADCAFE) begin
            bad++; $display("FAIL late_ack: got reqs=%0d berr=%b ld=%h want %0d 0 0badcafe",
                            m_reqs, m_berr, m_ld, c_timeout); end
    endtask

    task automatic test_reset_midreq();
        bit saw_done;
        opcode = c_op_lw; addr = 32'h400; mem_valid = 1'b1;
        bus_if.bus_ack = 1'b0;
        repeat (3) @(negedge clk);   // IDLE, REQ1, REQ2
        total++; if (bus_if.bus_req !== 1'b1) begin
            bad++; $display("FAIL midreq_req: got %b want 1", bus_if.bus_req); end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({stall_req, done, load_data, addr_err, bus_err, bus_if.bus_req, bus_if.bus_we,
             bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata} !== '0) begin
            bad++; $display("FAIL midreq_async: got stall=%b req=%b addr=%h be=%h, all want 0",
                            stall_req, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_be);
        end
        saw_done = 0;
        repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
        mem_valid = 1'b0; opcode = c_op_nop; rst = 1'b1;
        @(posedge clk); #1;
        if (done) saw_done = 1;
        total++; if (saw_done) begin
            bad++; $display("FAIL midreq_nodone: got done=1 want 0"); end
        run_access(c_op_lw, 32'h404, 32'h0, 32'h13579BDF, 1);
        total++; if (m_ld !== 32'h13579BDF || m_done_cyc != 4 || m_berr !== 1'b0) begin
            bad++; $display("FAIL midreq_after: got ld=%h cyc=%0d want 13579bdf 4", m_ld, m_done_cyc); end
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        ops = '{c_op_lb, c_op_lbu, c_op_lh, c_op_lhu, c_op_lw, c_op_sb, c_op_sh, c_op_sw};
        for (int it = 0; it < 40; it++) begin
            logic [5:0]  op;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rd;
            logic [31:0] exp_ld;
            int          n;
            int          w;
            int          exp_reqs;
            int          exp_cyc;
            bit          mis;
            bit          acked;
            if (it % 5 == 4) begin
                // Non-memory opcode, or memory opcode without mem_valid
                bit busy;
                busy = 0;
                mem_valid = $urandom_range(0, 1);
                opcode = mem_valid ? 6'($urandom_range(0, 31)) : c_op_lw;
                addr = $urandom;
                repeat (3) begin
                    @(negedge clk);
                    if (stall_req || done || bus_if.bus_req) busy = 1;
                end
                mem_valid = 1'b0; opcode = c_op_nop;
                @(posedge clk); #1;
                total++; if (busy) begin
                    bad++; $display("FAIL rnd_idle[%0d]: unit reacted to non-memory op %h", it, opcode); end
                continue;
            end
            op = ops[$urandom_range(0, 7)];
            n  = nbytes(op);
            a  = $urandom; wd = $urandom; rd = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~32'(n - 1);
            w = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
            mis      = (int'(a % 4) % n) != 0;
            acked    = (w >= 0);
            exp_reqs = mis ? 0 : (acked ? w + 1 : c_timeout);
            exp_cyc  = mis ? 2 : 2 + exp_reqs;
            exp_ld   = (mis || !acked || op_store(op)) ? 32'h0 : model_load(op, a, rd);
            run_access(op, a, wd, rd, w);
            total++;
            if (!m_got_done || m_done_cyc != exp_cyc || m_stalls != exp_cyc - 1 || m_reqs != exp_reqs) begin
                bad++; $display("FAIL rnd_timing[%0d]: op=%h a=%h got cyc=%0d stalls=%0d reqs=%0d want %0d %0d %0d",
                                it, op, a, m_done_cyc, m_stalls, m_reqs, exp_cyc, exp_cyc - 1, exp_reqs);
            end
            total++;
            if (m_ld !== exp_ld || m_aerr !== mis || m_berr !== (!mis && !acked) || m_leak) begin
                bad++; $display("FAIL rnd_result[%0d]: op=%h a=%h rd=%h got ld=%h aerr=%b berr=%b leak=%0d want ld=%h aerr=%b berr=%b",
                                it, op, a, rd, m_ld, m_aerr, m_berr, m_leak, exp_ld, mis, !mis && !acked);
            end
            if (!mis) begin
                total++;
                if (m_be !== model_be(n, int'(a % 4)) || m_addr !== (a & 32'hFFFF_FFFC) ||
                    m_we !== op_store(op) || m_wd !== wd || !m_stable) begin
                    bad++; $display("FAIL rnd_bus[%0d]: op=%h a=%h got be=%b addr=%h we=%b wd=%h stable=%0d want be=%b",
                                    it, op, a, m_be, m_addr, m_we, m_wd, m_stable, model_be(n, int'(a % 4)));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; mem_valid = 1'b0; opcode = c_op_nop; addr = '0; wdata = '0;
        bus_if.bus_rdata = '0; bus_if.bus_ack = 1'b0;
        test_reset();
        test_lw();
        test_lb();
        test_sh_wait();
        test_misaligned();
        test_timeout();
        test_reset_midreq();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
